// File: rtl/cci_mpf_shim_pkg.sv
// cci_mpf_shim_pkg: shim-internal client tags, arbitration limits and mdata tag helpers.
package cci_mpf_shim_pkg;

    typedef enum logic [0:0] {
        CCI_MPF_SHIM_TAG_VTP    = 1'b0,
        CCI_MPF_SHIM_TAG_PWRITE = 1'b1
    } t_cci_mpf_shim_tag;

    typedef logic [15:0] t_cci_mdata;

    localparam int CCI_MPF_SHIM_NUM_INT_CLIENTS = 2;
    localparam int CCI_MPF_SHIM_AFU_FAIR_LIMIT = 4;

    // Internal traffic carries the reserved bit plus the client tag in bit 0.
    function automatic t_cci_mdata cci_mpf_setShimMdataTag(int idx, t_cci_mpf_shim_tag tag);
        return (t_cci_mdata'(1) << idx) | t_cci_mdata'(tag);
    endfunction

    function automatic logic cci_mpf_testShimMdataTag(int idx, t_cci_mdata mdata);
        t_cci_mdata s;
        s = mdata >> idx;
        return s[0];
    endfunction

    function automatic t_cci_mpf_shim_tag cci_mpf_getShimMdataTag(t_cci_mdata mdata);
        return t_cci_mpf_shim_tag'(mdata[0]);
    endfunction

endpackage

// File: rtl/cci_mpf_shim_credit_ctr.sv
// cci_mpf_shim_credit_ctr: outstanding-read counter with full/zero flags, saturating at 0.
module cci_mpf_shim_credit_ctr #(
    parameter int MAX = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic zero
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (inc && !dec) cnt <= cnt + 1'b1;
        else if (dec && !inc && !zero) cnt <= cnt - 1'b1;
    end

    always_comb begin
        full = cnt == W'(MAX);
        zero = cnt == '0;
    end

endmodule

// File: rtl/cci_mpf_shim_int_rd_mux.sv
// cci_mpf_shim_int_rd_mux: merges AFU and shim-internal reads toward the FIU and steers responses back.
// Define MPF_SHIM_INT_RD_CHECK_EN to enable the sticky protocol error checks.
module cci_mpf_shim_int_rd_mux
    import cci_mpf_shim_pkg::*;
#(
    parameter int RESERVED_MDATA_IDX = 15,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               afu_rd_valid,
    input  logic [41:0]                                        afu_rd_addr,
    input  logic [15:0]                                        afu_rd_mdata,
    output logic                                               afu_rd_ready,
    input  logic [CCI_MPF_SHIM_NUM_INT_CLIENTS-1:0]            int_rd_valid,
    input  logic [CCI_MPF_SHIM_NUM_INT_CLIENTS-1:0][41:0]      int_rd_addr,
    output logic [CCI_MPF_SHIM_NUM_INT_CLIENTS-1:0]            int_rd_ready,
    output logic                                               fiu_rd_valid,
    output logic [41:0]                                        fiu_rd_addr,
    output logic [15:0]                                        fiu_rd_mdata,
    input  logic                                               fiu_almost_full,
    input  logic                                               fiu_rsp_valid,
    input  logic [15:0]                                        fiu_rsp_mdata,
    input  logic [511:0]                                       fiu_rsp_data,
    output logic                                               afu_rsp_valid,
    output logic [15:0]                                        afu_rsp_mdata,
    output logic [511:0]                                       afu_rsp_data,
    output logic [CCI_MPF_SHIM_NUM_INT_CLIENTS-1:0]            int_rsp_valid,
    output logic [511:0]                                       int_rsp_data,
    output logic                                               error
);

    localparam int N = CCI_MPF_SHIM_NUM_INT_CLIENTS;
    localparam int SW = $clog2(CCI_MPF_SHIM_AFU_FAIR_LIMIT + 1);
    localparam logic [SW-1:0] FAIR = SW'(CCI_MPF_SHIM_AFU_FAIR_LIMIT);

    logic [N-1:0] elig, full, zero, route, dec;
    logic [SW-1:0] streak;
    logic [511:0] rsp_data;
    t_cci_mpf_shim_tag rr, pick, next_rr, rsp_tag;
    logic go, afu_due, grant_int, grant_afu, reset_q, rsp_is_int, rsp_int;

    // Arbitration: internal first (round-robin), AFU forced in after FAIR internal grants.
    always_comb begin
        go = !reset && !fiu_almost_full;
        elig = int_rd_valid & ~full;
        afu_due = afu_rd_valid && (streak == FAIR || elig == '0);
        grant_afu = go && afu_due;
        grant_int = go && !afu_due && elig != '0;
        pick = elig[rr] ? rr : (rr == CCI_MPF_SHIM_TAG_VTP ? CCI_MPF_SHIM_TAG_PWRITE : CCI_MPF_SHIM_TAG_VTP);
        next_rr = pick == CCI_MPF_SHIM_TAG_VTP ? CCI_MPF_SHIM_TAG_PWRITE : CCI_MPF_SHIM_TAG_VTP;
        int_rd_ready = grant_int ? N'(1) << pick : '0;
        afu_rd_ready = grant_afu;
    end

    // Responses in the cycle right after reset belong to a dead epoch and are dropped.
    always_comb begin
        rsp_is_int = cci_mpf_testShimMdataTag(RESERVED_MDATA_IDX, fiu_rsp_mdata);
        rsp_tag = cci_mpf_getShimMdataTag(fiu_rsp_mdata);
        rsp_int = fiu_rsp_valid && !reset_q && rsp_is_int;
`ifdef MPF_SHIM_INT_RD_CHECK_EN
        route = (rsp_int && !zero[rsp_tag]) ? N'(1) << rsp_tag : '0;
`else
        route = rsp_int ? N'(1) << rsp_tag : '0;
`endif
        dec = route & (~zero | int_rd_ready);
    end

    for (genvar i = 0; i < N; i++) begin : g_ctr
        cci_mpf_shim_credit_ctr #(
            .MAX(MAX_OUTSTANDING)
        ) ctr (
            .clk(clk),
            .reset(reset),
            .inc(int_rd_ready[i]),
            .dec(dec[i]),
            .full(full[i]),
            .zero(zero[i])
        );
    end

    always_ff @(posedge clk) begin
        reset_q <= reset;
        if (reset) begin
            fiu_rd_valid <= 1'b0;
            afu_rsp_valid <= 1'b0;
            int_rsp_valid <= '0;
            rr <= CCI_MPF_SHIM_TAG_VTP;
            streak <= '0;
        end else begin
            fiu_rd_valid <= grant_int || grant_afu;
            afu_rsp_valid <= fiu_rsp_valid && !reset_q && !rsp_is_int;
            int_rsp_valid <= route;
            rr <= grant_int ? next_rr : rr;
            streak <= grant_int ? (streak == FAIR ? streak : streak + 1'b1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        fiu_rd_addr <= grant_afu ? afu_rd_addr : int_rd_addr[pick];
        fiu_rd_mdata <= grant_afu ? afu_rd_mdata : cci_mpf_setShimMdataTag(RESERVED_MDATA_IDX, pick);
        afu_rsp_mdata <= fiu_rsp_mdata;
        rsp_data <= fiu_rsp_data;
    end

    always_comb begin
        afu_rsp_data = rsp_data;
        int_rsp_data = rsp_data;
    end

`ifdef MPF_SHIM_INT_RD_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) error <= 1'b0;
        else if ((grant_afu && cci_mpf_testShimMdataTag(RESERVED_MDATA_IDX, afu_rd_mdata)) ||
                 (rsp_int && zero[rsp_tag])) error <= 1'b1;
    end
`else
    always_comb error = 1'b0;
`endif

endmodule

// File: tb/tb_cci_mpf_shim_int_rd_mux.sv
// tb_cci_mpf_shim_int_rd_mux: directed and random stimulus against a behavioural arbitration/credit model.
module tb_cci_mpf_shim_int_rd_mux;

    localparam int IDX = 15;
    localparam int MAX = 16;
`ifdef MPF_SHIM_INT_RD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic afu_rd_valid, afu_rd_ready, fiu_rd_valid, fiu_almost_full, fiu_rsp_valid, afu_rsp_valid, error;
    logic [41:0] afu_rd_addr, fiu_rd_addr;
    logic [15:0] afu_rd_mdata, fiu_rd_mdata, fiu_rsp_mdata, afu_rsp_mdata;
    logic [1:0] int_rd_valid, int_rd_ready, int_rsp_valid;
    logic [1:0][41:0] int_rd_addr;
    logic [511:0] fiu_rsp_data, afu_rsp_data, int_rsp_data;

    always #5 clk = ~clk;

    cci_mpf_shim_int_rd_mux #(
        .RESERVED_MDATA_IDX(IDX),
        .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .afu_rd_valid(afu_rd_valid),
        .afu_rd_addr(afu_rd_addr),
        .afu_rd_mdata(afu_rd_mdata),
        .afu_rd_ready(afu_rd_ready),
        .int_rd_valid(int_rd_valid),
        .int_rd_addr(int_rd_addr),
        .int_rd_ready(int_rd_ready),
        .fiu_rd_valid(fiu_rd_valid),
        .fiu_rd_addr(fiu_rd_addr),
        .fiu_rd_mdata(fiu_rd_mdata),
        .fiu_almost_full(fiu_almost_full),
        .fiu_rsp_valid(fiu_rsp_valid),
        .fiu_rsp_mdata(fiu_rsp_mdata),
        .fiu_rsp_data(fiu_rsp_data),
        .afu_rsp_valid(afu_rsp_valid),
        .afu_rsp_mdata(afu_rsp_mdata),
        .afu_rsp_data(afu_rsp_data),
        .int_rsp_valid(int_rsp_valid),
        .int_rsp_data(int_rsp_data),
        .error(error)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: outstanding reads per client, preferred client, internal streak.
    int m_cnt[2] = '{0, 0};
    int m_rr = 0;
    int m_streak = 0;
    int m_iv = 0;
    bit m_fv = 0, m_av = 0, m_err = 0, m_init = 1;
    logic [41:0] m_fa = '0;
    logic [15:0] m_fm = '0, m_rm = '0;
    logic [511:0] m_rd = '0;

    task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns -1 for no grant, 0/1 for an internal client, 2 for the AFU.
    function automatic int pick();
        if (reset || fiu_almost_full) return -1;
        if (afu_rd_valid && m_streak >= 4) return 2;
        for (int k = 0; k < 2; k++) begin
            int c = (m_rr + k) % 2;
            if (int_rd_valid[c] && m_cnt[c] < MAX) return c;
        end
        return afu_rd_valid ? 2 : -1;
    endfunction

    task automatic update(int g);
        int dec[2];
        int c, inc, d;
        if (reset) begin
            m_fv = 0; m_av = 0; m_iv = 0; m_err = 0; m_cnt = '{0, 0}; m_rr = 0; m_streak = 0; m_init = 1;
        end else begin
            dec = '{0, 0};
            m_fv = g >= 0;
            if (g == 2) begin
                m_fa = afu_rd_addr;
                m_fm = afu_rd_mdata;
                if (CHK && afu_rd_mdata[IDX]) m_err = 1;
            end else if (g >= 0) begin
                m_fa = int_rd_addr[g];
                m_fm = 16'(1 << IDX) | 16'(g);
            end
            m_av = 0;
            m_iv = 0;
            if (fiu_rsp_valid && !m_init) begin
                m_rd = fiu_rsp_data;
                if (fiu_rsp_mdata[IDX]) begin
                    c = int'(fiu_rsp_mdata[0]);
                    if (CHK && m_cnt[c] == 0) m_err = 1;
                    else begin
                        m_iv = 1 << c;
                        dec[c] = 1;
                    end
                end else begin
                    m_av = 1;
                    m_rm = fiu_rsp_mdata;
                end
            end
            for (int i = 0; i < 2; i++) begin
                inc = (g == i) ? 1 : 0;
                d = (dec[i] == 1 && (m_cnt[i] > 0 || inc == 1)) ? 1 : 0;
                m_cnt[i] = m_cnt[i] + inc - d;
            end
            if (g == 0 || g == 1) begin
                m_streak = m_streak < 4 ? m_streak + 1 : 4;
                m_rr = 1 - g;
            end else m_streak = 0;
            m_init = 0;
        end
    endtask

    task automatic cycle();
        int g;
        #4;
        g = pick();
        chk("int_rd_ready", int_rd_ready, g == 0 ? 1 : g == 1 ? 2 : 0);
        chk("afu_rd_ready", afu_rd_ready, g == 2);
        chk("fiu_rd_valid", fiu_rd_valid, m_fv);
        if (m_fv) begin
            chk("fiu_rd_addr", fiu_rd_addr, m_fa);
            chk("fiu_rd_mdata", fiu_rd_mdata, m_fm);
        end
        chk("afu_rsp_valid", afu_rsp_valid, m_av);
        chk("int_rsp_valid", int_rsp_valid, m_iv);
        if (m_av) chk("afu_rsp_mdata", afu_rsp_mdata, m_rm);
        if (m_av || m_iv != 0) begin
            chk("afu_rsp_data", afu_rsp_data, m_rd);
            chk("int_rsp_data", int_rsp_data, m_rd);
        end
        chk("rsp_onehot", $countones({afu_rsp_valid, int_rsp_valid}) <= 1, 1);
        chk("error", error, m_err);
        @(posedge clk);
        update(g);
        #1;
    endtask

    task automatic drive(logic [1:0] iv, logic av, logic af, logic rv, logic [15:0] rm);
        int_rd_valid = iv;
        afu_rd_valid = av;
        fiu_almost_full = af;
        fiu_rsp_valid = rv;
        fiu_rsp_mdata = rm;
        int_rd_addr[0] = 42'({$urandom(), $urandom()});
        int_rd_addr[1] = 42'({$urandom(), $urandom()});
        afu_rd_addr = 42'({$urandom(), $urandom()});
        afu_rd_mdata = {1'b0, 15'($urandom())};
        for (int k = 0; k < 16; k++) fiu_rsp_data[k*32 +: 32] = $urandom();
    endtask

    initial begin
        reset = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        // Requests held valid during reset must see no ready.
        drive(2'b11, 1'b1, 1'b0, 1'b0, 16'h0);
        cycle();
        cycle();
        // Response in the first cycle after reset is dropped.
        reset = 1'b0;
        drive(2'b11, 1'b1, 1'b0, 1'b1, 16'h8000);
        cycle();
        // Fair sequence: VTP, PWRITE, VTP, PWRITE, AFU, repeat.
        repeat (10) begin drive(2'b11, 1'b1, 1'b0, 1'b0, 16'h0); cycle(); end
        // Almost-full stalls every requester.
        repeat (10) begin drive(2'b11, 1'b1, 1'b1, 1'b0, 16'h0); cycle(); end
        drive(2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        // VTP runs out of credit at 16, one response returns it.
        repeat (18) begin drive(2'b01, 1'b0, 1'b0, 1'b0, 16'h0); cycle(); end
        drive(2'b01, 1'b0, 1'b0, 1'b1, 16'h8000);
        cycle();
        repeat (3) begin drive(2'b01, 1'b0, 1'b0, 1'b0, 16'h0); cycle(); end
        // Response steering.
        drive(2'b00, 1'b0, 1'b0, 1'b1, 16'h8001);
        cycle();
        drive(2'b00, 1'b0, 1'b0, 1'b1, 16'h0001);
        cycle();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
        cycle();
        // Simultaneous grant and response at count 5.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        repeat (5) begin drive(2'b01, 1'b0, 1'b0, 1'b0, 16'h0); cycle(); end
        drive(2'b01, 1'b0, 1'b0, 1'b1, 16'h8000);
        cycle();
        repeat (12) begin drive(2'b01, 1'b0, 1'b0, 1'b0, 16'h0); cycle(); end
        // AFU request carrying the reserved mdata bit.
        drive(2'b00, 1'b1, 1'b0, 1'b0, 16'h0);
        afu_rd_mdata = 16'h8000;
        cycle();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
        cycle();
        cycle();
        // Random traffic with occasional resets.
        repeat (400) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                  1'($urandom_range(0, 1)), 16'h0);
            case ($urandom_range(0, 3))
                0: fiu_rsp_mdata = 16'h8000;
                1: fiu_rsp_mdata = 16'h8001;
                default: fiu_rsp_mdata = {1'b0, 15'($urandom())};
            endcase
            if ($urandom_range(0, 7) == 0) afu_rd_mdata = 16'($urandom());
            reset = $urandom_range(0, 99) == 0;
            cycle();
        end
        // Reset in the middle of traffic.
        reset = 1'b0;
        drive(2'b11, 1'b1, 1'b0, 1'b1, 16'h8001);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
        cycle();
        cycle();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cci_mpf_shim_int_rd_mux.md
CCI_MPF_SHIM_INT_RD_MUX -- requirements
Module: cci_mpf_shim_int_rd_mux

Interface
REQ-001 SHALL have parameter RESERVED_MDATA_IDX, default 15: the mdata bit that marks shim-internal traffic.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 16: the per-internal-client read credit limit, in the range 1..64.
REQ-003 SHALL have clk  in  1: the single clock; all logic is on the rising edge.
REQ-004 SHALL have reset  in  1: reset is synchronous and active-high.
REQ-005 SHALL have afu_rd_valid in 1, afu_rd_addr in 42, afu_rd_mdata in 16, afu_rd_ready out 1: the AFU read request.
REQ-006 SHALL have int_rd_valid in 2, int_rd_addr in 2x42, int_rd_ready out 2: internal read requests, index = t_cci_mpf_shim_tag (0 VTP, 1 PWRITE).
REQ-007 SHALL have fiu_rd_valid out 1, fiu_rd_addr out 42, fiu_rd_mdata out 16, fiu_almost_full in 1: the merged request towards the FIU.
REQ-008 SHALL have fiu_rsp_valid in 1, fiu_rsp_mdata in 16, fiu_rsp_data in 512: the read response from the FIU.
REQ-009 SHALL have afu_rsp_valid out 1, afu_rsp_mdata out 16, afu_rsp_data out 512: responses passed to the AFU.
REQ-010 SHALL have int_rsp_valid out 2, int_rsp_data out 512: responses to the internal clients (data shared).
REQ-011 SHALL have error out 1: a sticky protocol-violation flag.

Function
REQ-012 SHALL register the request path: a grant in cycle N drives fiu_rd_* in cycle N+1; fiu_rd_valid deasserts in any cycle with no grant.
REQ-013 SHALL grant nothing in any cycle where fiu_almost_full=1; all ready outputs are then 0.
REQ-014 SHALL assert ready combinationally only for the granted requester; a transfer is valid&&ready.
REQ-015 SHALL give internal clients priority over the AFU, round-robin between the two, and start with VTP after reset.
REQ-016 SHALL grant a valid AFU request after 4 consecutive internal grants, even when internal requests are pending; the streak counter clears on any AFU grant or idle cycle.
REQ-017 SHALL make an internal client ineligible while its outstanding count equals MAX_OUTSTANDING.
REQ-018 SHALL set fiu_rd_mdata for an internal grant to cci_mpf_setShimMdataTag(RESERVED_MDATA_IDX, client).
REQ-019 SHALL forward AFU mdata unchanged on an AFU grant.
REQ-020 SHALL keep a per-client outstanding counter: +1 on grant, -1 on a matching response; simultaneous +1/-1 leaves it unchanged.
REQ-021 SHALL steer responses with 1-cycle registered latency: reserved bit set -> int_rsp_valid[mdata[0]]; otherwise -> afu_rsp_* with mdata unchanged.
REQ-022 SHALL never assert more than one response-valid output in a cycle.

Reset
REQ-023 SHALL drive to 0 during and after reset: all valid outputs, all ready outputs, counters, round-robin pointer (VTP), streak counter and error.
REQ-024 SHALL drop a response arriving in the first cycle after reset, with no valid output.
REQ-025 SHALL route responses to pre-reset requests per REQ-021, with counter decrements saturating at 0.

Configuration
REQ-026 With MPF_SHIM_INT_RD_CHECK_EN defined, SHALL set error for an AFU request with afu_rd_mdata[RESERVED_MDATA_IDX]=1; the request is still forwarded.
REQ-027 With MPF_SHIM_INT_RD_CHECK_EN defined, SHALL set error for an internal response whose client counter is 0; that response is dropped.
REQ-028 Without MPF_SHIM_INT_RD_CHECK_EN, SHALL tie error to 0 and include no check logic.

Structure
REQ-029 SHALL place CCI_MPF_SHIM_NUM_INT_CLIENTS (=2) and the AFU fairness limit (=4) in cci_mpf_shim_pkg, reusing t_cci_mpf_shim_tag and the tag set/test functions there.
REQ-030 SHALL implement each outstanding counter as sub-module cci_mpf_shim_credit_ctr (inc, dec, full, zero, saturate at 0), instantiated twice.

Verification
REQ-031 Both internal clients and the AFU valid continuously, almost_full=0 -> grants VTP, PWRITE, VTP, PWRITE, AFU, then repeat.
REQ-032 VTP issues 16 reads with no responses -> int_rd_ready[0]=0 from the 17th; one response with mdata=16'h8000 -> ready returns the next cycle.
REQ-033 Response mdata=16'h8001 -> int_rsp_valid=2'b10 one cycle later; mdata=16'h0001 -> afu_rsp_valid=1, afu_rsp_mdata=16'h0001.
REQ-034 fiu_almost_full=1 for 10 cycles with all requesters valid -> zero grants and fiu_rd_valid=0 for cycles 2..11.
REQ-035 Grant and response for VTP in the same cycle at count 5 -> count stays 5.
REQ-036 With CHECK_EN, an AFU request with mdata=16'h8000 -> error=1 and held until reset; a reset mid-traffic clears all outputs in the next cycle.
